// File: rtl/uart_tx_hex_fmt.sv
// -----------------------------------------------------------------------------
// uart_tx_hex_fmt
//
// Response formatter that sits directly in front of uart_tx. It takes one binary
// result word and sends it as uppercase ASCII hex, most significant nibble
// first. When ADD_CRLF is set, it follows the digits with CR (0x0D) and LF
// (0x0A). Bytes go to uart_tx one at a time over its DV/Active/Done handshake,
// so the command interpreter never sequences individual characters.
//
// Parameters:
//   NUM_NIBBLES  hex digits per word (1..8); word width is 4*NUM_NIBBLES
//   ADD_CRLF     1 = append CR LF after the digits, 0 = digits only
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Word_DV    one-cycle strobe, i_Word valid (ignored while o_Busy)
//   i_Word       word to format
//   o_Busy       high from accept until the last byte's Done has been seen
//   o_Fmt_Done   one-cycle pulse when the whole message has completed
//   o_Tx_DV      to uart_tx i_Tx_DV, one-cycle pulse per byte
//   o_Tx_Byte    to uart_tx i_Tx_Byte, valid while o_Tx_DV is high
//   i_Tx_Active  from uart_tx o_Tx_Active
//   i_Tx_Done    from uart_tx o_Tx_Done
// -----------------------------------------------------------------------------
module uart_tx_hex_fmt #(
  parameter int NUM_NIBBLES = 8,
  parameter bit ADD_CRLF    = 1'b1
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic                     i_Word_DV,
  input  logic [4*NUM_NIBBLES-1:0] i_Word,
  output logic                     o_Busy,
  output logic                     o_Fmt_Done,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done
);

  localparam int         WORD_W      = 4 * NUM_NIBBLES;
  localparam int         TOTAL_CHARS = NUM_NIBBLES + (ADD_CRLF ? 2 : 0);
  localparam logic [3:0] NIB_CNT     = 4'(NUM_NIBBLES);
  localparam logic [3:0] LAST_IDX    = 4'(TOTAL_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [3:0]        char_cnt;
  logic [3:0]        top_nib;
  logic [7:0]        cur_char;

  // Character for the current counter position. The next digit to send is
  // always in the top nibble because the shift register moves left after
  // each digit's Done.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    top_nib  = shift_reg[WORD_W-1 -: 4];
    cur_char = 8'h00;
    if (char_cnt < NIB_CNT) begin
      if (top_nib <= 4'd9) begin
        cur_char = 8'h30 + {4'h0, top_nib};
      end else begin
        cur_char = 8'h37 + {4'h0, top_nib};
      end
    end else if (char_cnt == NIB_CNT) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
  end

  // NOTE: all state and outputs are updated with non-blocking assignments.
  // Every register then takes the value computed from pre-edge state,
  // regardless of the statement order inside this block.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      char_cnt   <= 4'd0;
      o_Busy     <= 1'b0;
      o_Fmt_Done <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
    end else begin
      // Both strobes default low. This makes every pulse exactly one cycle wide.
      o_Tx_DV    <= 1'b0;
      o_Fmt_Done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_Word_DV) begin
            shift_reg <= i_Word;
            char_cnt  <= 4'd0;
            o_Busy    <= 1'b1;
            state     <= S_LOAD;
          end
        end

        // uart_tx latches a byte only from its idle state. Done is still high
        // during the first idle cycle after the previous byte, so both Active
        // and Done must be low. This also keeps the second Done cycle from
        // being counted twice.
        S_LOAD: begin
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= cur_char;
            state     <= S_WAIT_ACT;
          end
        end

        S_WAIT_ACT: begin
          if (i_Tx_Active) begin
            state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            if (char_cnt < NIB_CNT) begin
              shift_reg <= shift_reg << 4;
            end
            char_cnt <= char_cnt + 4'd1;
            state    <= (char_cnt == LAST_IDX) ? S_FINISH : S_LOAD;
          end
        end

        S_FINISH: begin
          o_Fmt_Done <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_hex_fmt.md
Name: uart_tx_hex_fmt

Overview:
- Response formatter sitting directly upstream of uart_tx in the command interface.
- Accepts one binary result word from the command interpreter and emits it as uppercase ASCII hex, MSB nibble first, optionally followed by CR LF.
- Hands bytes to uart_tx one at a time over uart_tx's DV/Active/Done handshake.
- Frees the interpreter from per-character sequencing.

Parameters:
- NUM_NIBBLES, 8, hex digits per word; data width is 4*NUM_NIBBLES; legal range 1..8.
- ADD_CRLF, 1, 1 = append 0x0D then 0x0A after the digits; 0 = digits only.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Word_DV  input  1  one-cycle strobe: i_Word is valid.
- i_Word  input  4*NUM_NIBBLES  word to format.
- o_Busy  output  1  high from accept until the last byte's Done is seen.
- o_Fmt_Done  output  1  one-cycle pulse when the whole message has completed.
- o_Tx_DV  output  1  to uart_tx i_Tx_DV; one-cycle pulse per byte.
- o_Tx_Byte  output  8  to uart_tx i_Tx_Byte; valid while o_Tx_DV is high.
- i_Tx_Active  input  1  from uart_tx o_Tx_Active.
- i_Tx_Done  input  1  from uart_tx o_Tx_Done.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; o_Busy, o_Fmt_Done and o_Tx_DV = 0; o_Tx_Byte, shift register and char counter = 0.
- States: IDLE, LOAD, WAIT_ACT, WAIT_DONE, FINISH.
- IDLE:
  - If i_Word_DV=1, capture i_Word into the shift register, clear the char counter, set o_Busy=1, go to LOAD.
  - i_Word_DV while o_Busy=1 is ignored. No queueing, no error flag.
- LOAD:
  - Wait until i_Tx_Active=0 and i_Tx_Done=0 in the same cycle. This guarantees uart_tx is in its idle state and will latch the byte.
  - Then drive o_Tx_DV=1 for exactly one cycle with o_Tx_Byte = current char, and go to WAIT_ACT.
  - Minimum latency: accept cycle to o_Tx_DV high is 1 cycle.
- Char selection:
  - Counter below NUM_NIBBLES: the top nibble n of the shift register maps to 0x30+n for n<=9 and 0x37+n for n>=10 (uppercase 'A'..'F').
  - Counter = NUM_NIBBLES: 0x0D. Counter = NUM_NIBBLES+1: 0x0A. These apply only when ADD_CRLF=1.
- WAIT_ACT: wait for i_Tx_Active=1, then go to WAIT_DONE. o_Tx_DV must never be held high across cycles; uart_tx re-triggers on DV at stop-bit end without relatching data.
- WAIT_DONE:
  - On i_Tx_Done=1: shift register left 4 if a digit was sent; increment counter.
  - If counter+1 = total chars (NUM_NIBBLES + 2*ADD_CRLF), go to FINISH. Otherwise go to LOAD.
  - i_Tx_Done stays high for 2 cycles. LOAD's Done=0 check prevents double-counting.
- FINISH: pulse o_Fmt_Done=1 for one cycle, clear o_Busy in the same edge, return to IDLE. A new i_Word_DV is accepted in the cycle after FINISH.
- Width rules: counter is 4 bits, so 10 chars max fits. Shift register does not wrap; vacated low nibbles fill with 0.
- Reset mid-message: the message is abandoned with no partial Done pulse. uart_tx has no reset and may finish its current byte. A following word waits in LOAD until that byte's Done has cleared.
- Simultaneous i_Word_DV and FINISH: the word is ignored, because o_Busy is still 1 that cycle.

Test Plan:
- NUM_NIBBLES=8, ADD_CRLF=1, uart_tx model CLKS_PER_BIT=4; i_Word=0x1234ABCD -> bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A; exactly 10 o_Tx_DV pulses; one o_Fmt_Done pulse; o_Busy falls in the same cycle as that pulse.
- i_Word=0x00000000 then 0xFFFFFFFF back-to-back, the second strobed the cycle after o_Fmt_Done -> "00000000\r\n" then "FFFFFFFF\r\n"; the second word is accepted.
- i_Word_DV=0x55 pulsed while o_Busy=1 during word 0x0000000F -> only "0000000F\r\n" is sent; the ignored word never appears.
- NUM_NIBBLES=2, ADD_CRLF=0, i_Word=0x9A -> bytes 0x39 0x41 only; o_Fmt_Done follows the 2nd Done.
- Reset asserted in WAIT_DONE of char 3, then word 0xBEEF0001 -> all outputs 0 immediately; no o_Tx_DV until uart Active and Done are both low; then the full "BEEF0001\r\n" with no corrupted byte.
- Check every o_Tx_DV is high for exactly 1 cycle and never asserted while i_Tx_Active=1 or i_Tx_Done=1.
